// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 matrix keypad, debounces one key press
// and emits its code {row_idx, col_idx} with a one-cycle rd_enable.
// Ports: clock, reset (sync, active-high); col[3:0] in (async);
//        row[3:0] one-hot drive, code[3:0], rd_enable, key_held out.
module keypad_encoder #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] code,
    output logic       rd_enable,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ?
                             SCAN_DWELL : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_EMIT,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    code_q, code_d;

    logic [3:0]    col_s;
    logic [1:0]    low_col;
    logic          cap_bit;

    assign col_s   = sync2_q;
    assign cap_bit = col_s[col_idx_q];

    // Lowest asserted column wins when several keys share the row.
    always_comb begin
        low_col = 2'd3;
        priority case (1'b1)
            col_s[0]: low_col = 2'd0;
            col_s[1]: low_col = 2'd1;
            col_s[2]: low_col = 2'd2;
            default:  low_col = 2'd3;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_SCAN;
            cnt_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            row_idx_q <= '0;
            col_idx_q <= '0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sync1_d   = col;
        sync2_d   = sync1_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        code_d    = code_q;
        unique case (state_q)
            S_SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (col_s != 4'b0000) begin
                        col_idx_d = low_col;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (!cap_bit) begin
                    // Bounce: give up and move on to the next row.
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = S_SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    // Code is loaded on EMIT entry so it is valid with the strobe.
                    cnt_d   = '0;
                    code_d  = {row_idx_q, col_idx_q};
                    state_d = S_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_EMIT: begin
                cnt_d   = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!cap_bit) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (cap_bit) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + 2'd1;
                    state_d   = S_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_SCAN;
            end
        endcase
    end

    always_comb begin
        row       = 4'b0001 << row_idx_q;
        code      = code_q;
        rd_enable = (state_q == S_EMIT);
        key_held  = (state_q == S_HOLD) || (state_q == S_RELEASE);
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: directed table-driven bench for keypad_encoder
// with a behavioural 4x4 key matrix model driving col from row.
module tb_keypad_encoder;

    logic       clock;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] code;
    logic       rd_enable;
    logic       key_held;

    logic [15:0] pressed;

    int n_checks;
    int n_fail;
    int strobes;
    int consec;
    logic prev_rd;

    keypad_encoder #(
        .SCAN_DWELL(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .col(col),
        .row(row),
        .code(code),
        .rd_enable(rd_enable),
        .key_held(key_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Key at (r,c) is bit 4r+c; it shorts row r onto column c.
    always_comb begin
        col = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row[r] && pressed[4*r+c])
                    col[c] = 1'b1;
    end

    typedef struct {
        string       name;
        logic [15:0] mask;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (rd_enable === 1'b1) begin
            strobes++;
            if (prev_rd === 1'b1) consec++;
        end
        prev_rd = rd_enable;
    endtask

    task automatic apply_reset(input logic [15:0] mask);
        @(negedge clock);
        reset   = 1'b1;
        pressed = mask;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input string nm);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (rd_enable === 1'b1) found = 1'b1;
        end
        check({nm, "_strobe_seen"}, 32'(found), 32'd1);
    endtask

    task automatic wait_held_low(input string nm);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (key_held === 1'b0) found = 1'b1;
        end
        check({nm, "_held_low"}, 32'(found), 32'd1);
    endtask

    initial begin
        int   s0;
        logic dropped;
        logic [15:0] bounce;

        n_checks = 0;
        n_fail   = 0;
        strobes  = 0;
        consec   = 0;
        prev_rd  = 1'b0;
        reset    = 1'b1;
        pressed  = '0;

        tbl[0] = '{"k33", 16'h8000, 4'hF};
        tbl[1] = '{"k21", 16'h0200, 4'h9};
        tbl[2] = '{"k10_k13", 16'h0090, 4'h4};
        tbl[3] = '{"k00", 16'h0001, 4'h0};
        tbl[4] = '{"k23", 16'h0800, 4'hB};
        tbl[5] = '{"k30", 16'h1000, 4'hC};

        // Reset state
        apply_reset(16'h0000);
        check("rst_row", 32'(row), 32'h1);
        check("rst_code", 32'(code), 32'h0);
        check("rst_rd", 32'(rd_enable), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);

        // Latency: key (0,2) stable from reset release
        apply_reset(16'h0004);
        s0 = strobes;
        repeat (7) step();
        check("lat_rd_pre", 32'(rd_enable), 32'h0);
        check("lat_no_early", 32'(strobes), 32'(s0));
        step();
        check("lat_rd_edge8", 32'(rd_enable), 32'h1);
        check("lat_code", 32'(code), 32'h2);
        step();
        check("lat_rd_one", 32'(rd_enable), 32'h0);
        check("lat_held_rise", 32'(key_held), 32'h1);
        repeat (1000) step();
        check("hold1000_strobes", 32'(strobes), 32'(s0 + 1));
        check("hold1000_held", 32'(key_held), 32'h1);
        pressed = '0;
        repeat (6) step();
        check("rel_held_pre", 32'(key_held), 32'h1);
        step();
        check("rel_held_fall", 32'(key_held), 32'h0);
        check("rel_strobes", 32'(strobes), 32'(s0 + 1));

        // Table of single presses / same-row multi-press
        for (int i = 0; i < 6; i++) begin
            s0 = strobes;
            pressed = tbl[i].mask;
            wait_strobe(tbl[i].name);
            check({tbl[i].name, "_code"}, 32'(code), 32'(tbl[i].exp_code));
            repeat (20) step();
            check({tbl[i].name, "_held"}, 32'(key_held), 32'h1);
            check({tbl[i].name, "_one"}, 32'(strobes), 32'(s0 + 1));
            pressed = '0;
            wait_held_low(tbl[i].name);
            repeat (10) step();
            check({tbl[i].name, "_no_extra"}, 32'(strobes), 32'(s0 + 1));
        end

        // Key added in another row during HOLD is ignored until release
        s0 = strobes;
        pressed = 16'h0090;
        wait_strobe("hold_ign");
        check("hold_ign_code", 32'(code), 32'h4);
        repeat (5) step();
        pressed = 16'h0290;
        repeat (20) step();
        check("hold_ign_none", 32'(strobes), 32'(s0 + 1));
        check("hold_ign_code_kept", 32'(code), 32'h4);
        pressed = 16'h0200;
        wait_held_low("hold_ign");
        wait_strobe("hold_ign_next");
        check("hold_ign_next_code", 32'(code), 32'h9);
        check("hold_ign_count", 32'(strobes), 32'(s0 + 2));
        pressed = '0;
        wait_held_low("hold_ign_next");

        // Release bounce 0,0,1 returns to HOLD without a new strobe
        s0 = strobes;
        pressed = 16'h0040;
        wait_strobe("rel_b");
        check("rel_b_code", 32'(code), 32'h6);
        repeat (5) step();
        pressed = '0;
        step();
        step();
        pressed = 16'h0040;
        dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_held !== 1'b1) dropped = 1'b1;
        end
        check("rel_b_held_kept", 32'(dropped), 32'h0);
        check("rel_b_none", 32'(strobes), 32'(s0 + 1));
        pressed = '0;
        repeat (6) step();
        check("rel_b_held_pre", 32'(key_held), 32'h1);
        step();
        check("rel_b_held_fall", 32'(key_held), 32'h0);
        check("rel_b_none2", 32'(strobes), 32'(s0 + 1));

        // Press bounce: col seen at edges 3..7 is 1,0,1,1,0
        bounce = 16'b0000_0000_0110_1110;
        apply_reset(16'h0002);
        s0 = strobes;
        for (int k = 1; k <= 7; k++) begin
            pressed = bounce[k] ? 16'h0002 : 16'h0000;
            step();
        end
        pressed = '0;
        repeat (30) step();
        check("pb_none", 32'(strobes), 32'(s0));
        check("pb_held", 32'(key_held), 32'h0);
        pressed = 16'h0002;
        wait_strobe("pb");
        check("pb_code", 32'(code), 32'h1);
        repeat (10) step();
        check("pb_one", 32'(strobes), 32'(s0 + 1));
        pressed = '0;
        wait_held_low("pb");

        // Reset during DEBOUNCE
        apply_reset(16'h0008);
        s0 = strobes;
        repeat (5) step();
        check("rd_deb_pre", 32'(rd_enable), 32'h0);
        reset = 1'b1;
        step();
        check("rst_deb_row", 32'(row), 32'h1);
        check("rst_deb_code", 32'(code), 32'h0);
        check("rst_deb_rd", 32'(rd_enable), 32'h0);
        check("rst_deb_held", 32'(key_held), 32'h0);
        step();
        check("rst_deb_none", 32'(strobes), 32'(s0));

        // Reset in the EMIT cycle
        reset = 1'b0;
        repeat (8) step();
        check("emit_rd", 32'(rd_enable), 32'h1);
        check("emit_code", 32'(code), 32'h3);
        reset = 1'b1;
        step();
        check("rst_emit_row", 32'(row), 32'h1);
        check("rst_emit_code", 32'(code), 32'h0);
        check("rst_emit_rd", 32'(rd_enable), 32'h0);
        check("rst_emit_held", 32'(key_held), 32'h0);
        pressed = '0;
        reset = 1'b0;
        repeat (5) step();

        check("no_back_to_back", 32'(consec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
# keypad_encoder

Scans a 4x4 matrix keypad, debounces a single key press and emits its 4-bit key code with a one-cycle `rd_enable` strobe. It is the producing end of the `code`/`rd_enable` interface consumed by the keypad-to-BCD decoder. It drives keypad rows, samples columns through a synchronizer, and reports each press exactly once, regardless of hold time or contact bounce.

## Interface
- `SCAN_DWELL`, default 4: cycles each row is driven before its columns are evaluated; legal range ≥3.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release; legal range ≥1.
- `clock`  input  1  sole clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `col`  input  4  keypad column lines; active-high; asynchronous to `clock`.
- `row`  output  4  one-hot active-high row drive.
- `code`  output  4  key code `{row_idx[1:0], col_idx[1:0]}`; holds the last emitted value.
- `rd_enable`  output  1  one-cycle strobe; `code` is valid in that cycle.
- `key_held`  output  1  high while an accepted key remains pressed, up to release acceptance.

## Operation
- `col` passes through a 2-flop synchronizer to produce `col_s`. All decisions use `col_s`.
- Key mapping: key at row r, column c gives code 4r+c (0..15).
- FSM states and transitions:
  - **SCAN**
    - `row` rotates 0001→0010→0100→1000→0001, advancing every `SCAN_DWELL` cycles.
    - `col_s` is evaluated only on the last dwell cycle of each row.
    - If `col_s` is nonzero at that point, capture `row_idx` and the lowest set column index, freeze `row`, clear the counter, and go to DEBOUNCE.
  - **DEBOUNCE**
    - Each cycle the captured column bit is 1, increment the counter. On the cycle the count reaches `DEBOUNCE_CYCLES`, go to EMIT.
    - If the captured bit is 0 in any cycle, return to SCAN with the next row and a fresh dwell. No strobe is issued.
  - **EMIT**
    - Exactly one cycle: load `code`, assert `rd_enable`, then go to HOLD.
  - **HOLD**
    - `key_held`=1. Stay while the captured bit is 1.
    - On 0, clear the counter and go to RELEASE.
  - **RELEASE**
    - `key_held`=1. Count consecutive cycles with the captured bit at 0.
    - At `DEBOUNCE_CYCLES`, go to SCAN starting at the next row.
    - Any 1 returns to HOLD with no new strobe.
- Simultaneous keys:
  - Within the driven row, the lowest column index wins.
  - Keys in other rows are ignored while a key is captured.
  - Other columns changing during HOLD or RELEASE are ignored.
- Widths and counters:
  - Counter width is `$clog2(max(SCAN_DWELL,DEBOUNCE_CYCLES)+1)`.
  - Counters never wrap in any state; each is cleared on every state entry.
- `code` changes only in EMIT.

## Timing
- Reset values: `row`=4'b0001, `code`=4'b0000, `rd_enable`=0, `key_held`=0. FSM is in SCAN, counters and synchronizer are cleared.
- Reset asserted mid-operation: outputs take reset values on the next edge. A pending EMIT is discarded and no strobe is issued.
- Latency: a key stable from reset release in row 0 produces `rd_enable` high in the cycle after rising edge `SCAN_DWELL`+`DEBOUNCE_CYCLES`. With defaults, that is after edge 8.
  - For row r, add r×`SCAN_DWELL` cycles.
- Row-to-column delay: `SCAN_DWELL` ≥3 covers the 2-cycle synchronizer, so the evaluated `col_s` reflects the current row.
- `rd_enable` is never high in two consecutive cycles. At least `DEBOUNCE_CYCLES`+2 cycles separate strobes.
- `key_held` rises the cycle after the strobe and falls on release acceptance.

## Test plan
- Reset, then hold key (row0, col2) stable with defaults:
  - `rd_enable` pulses once after edge 8 with `code`=4'h2.
  - `key_held` stays 1 until release plus 4 cycles; no second pulse over 1000 held cycles.
- Press key (row3, col3) → `code`=4'hF with one `rd_enable` pulse. Release and press (row2, col1) → `code`=4'h9 with one pulse.
- Bounce on press: the captured column toggles 1,0,1,1,0 within the debounce window → no strobe. Then stable for 4+ cycles → exactly one strobe.
- Bounce on release: 0,0,1 during RELEASE → returns to HOLD with no new strobe. Then 4 zeros → back to SCAN with `key_held`=0.
- Keys (row1, col0) and (row1, col3) pressed together → `code`=4'h4. A key (row2, col1) added during HOLD is ignored until release.
- `reset` asserted in DEBOUNCE and in the EMIT cycle → next cycle shows `row`=0001, `code`=0, `rd_enable`=0, `key_held`=0.
